// File: rtl/bus_arbiter_v35_pkg.sv
// bus_arbiter_v35_pkg: shared state/requester encodings and default tuning constants for the bus arbiter
package bus_arbiter_v35_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_e;
    typedef enum logic [1:0] {
        ARB_EU   = 2'd0,
        ARB_DMA  = 2'd1,
        ARB_RFSH = 2'd2,
        ARB_NONE = 2'd3
    } arb_req_e;
    localparam int RFSH_URGENT_DEF = 8;
    localparam int AGE_W_DEF       = 4;
endpackage

// File: rtl/bus_arbiter_v35_pick.sv
// bus_arb_pick: combinational winner select (lock, urgent refresh, then DMA > EU > RFSH)
module bus_arb_pick
    import bus_arbiter_v35_pkg::*;
#(
    parameter int AGE_W       = AGE_W_DEF,
    parameter int RFSH_URGENT = RFSH_URGENT_DEF
) (
    input  logic [2:0]       req,
    input  logic [AGE_W-1:0] rfsh_age,
    input  logic             locked,
    output arb_req_e         winner
);
    logic urgent;
    always_comb begin
        urgent = req[2] && (rfsh_age >= AGE_W'(RFSH_URGENT));
        winner = locked ? (req[0] ? ARB_EU : ARB_NONE)
               : urgent ? ARB_RFSH
               : req[1] ? ARB_DMA
               : req[0] ? ARB_EU
               : req[2] ? ARB_RFSH
               : ARB_NONE;
    end
endmodule

// File: rtl/bus_arbiter_v35.sv
// bus_arbiter_v35: shares the bus control unit data-pointer port between EU, DMA and refresh
module bus_arbiter_v35
    import bus_arbiter_v35_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int RFSH_URGENT = RFSH_URGENT_DEF,
    parameter int AGE_W       = AGE_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce_1,
    input  logic                  ce_2,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0][19:0] req_addr,
    input  logic [NREQ-1:0][15:0] req_dout,
    input  logic [NREQ-1:0]       req_write,
    input  logic [NREQ-1:0]       req_wide,
    input  logic [NREQ-1:0]       req_io,
    input  logic                  eu_lock,
    output logic [NREQ-1:0]       done,
    output logic [15:0]           rdata,
    output logic [1:0]            owner,
    output logic [19:0]           dp_addr,
    output logic [15:0]           dp_dout,
    output logic                  dp_write,
    output logic                  dp_wide,
    output logic                  dp_io,
    output logic                  dp_req,
    input  logic [15:0]           dp_din,
    input  logic                  dp_ready
);
    arb_state_e                   state_q;
    logic [1:0]                   owner_q;
    logic [NREQ-1:0]              done_q;
    logic [15:0]                  rdata_q;
    logic [19:0]                  dp_addr_q;
    logic [15:0]                  dp_dout_q;
    logic                         dp_write_q;
    logic                         dp_wide_q;
    logic                         dp_io_q;
    logic                         dp_req_q;
    logic                         locked_q;
    logic [NREQ-1:0][AGE_W-1:0]   age_q;
    logic [NREQ-1:0][AGE_W-1:0]   age_d;
    arb_req_e                     winner;
    logic [1:0]                   w;
    logic                         grant;
    logic                         unused_ce2;

    assign unused_ce2 = ce_2;
    assign w          = winner;
    assign grant      = (state_q == ARB_IDLE) && dp_ready && (winner != ARB_NONE);

    // A held lock only constrains arbitration while the EU still asserts eu_lock.
    bus_arb_pick #(
        .AGE_W       (AGE_W),
        .RFSH_URGENT (RFSH_URGENT)
    ) u_pick (
        .req      (req),
        .rfsh_age (age_q[ARB_RFSH]),
        .locked   (locked_q && eu_lock),
        .winner   (winner)
    );

    always_comb begin
        age_d = age_q;
        for (int i = 0; i < NREQ; i++)
            age_d[i] = (grant && w == 2'(i)) ? '0
                     : (req[i] && owner_q != 2'(i) && age_q[i] != '1) ? age_q[i] + 1'b1
                     : age_q[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= ARB_NONE;
            done_q     <= '0;
            rdata_q    <= '0;
            dp_addr_q  <= '0;
            dp_dout_q  <= '0;
            dp_write_q <= 1'b0;
            dp_wide_q  <= 1'b0;
            dp_io_q    <= 1'b0;
            dp_req_q   <= 1'b0;
            locked_q   <= 1'b0;
            age_q      <= '0;
        end else begin
            done_q <= '0;
            if (ce_1) begin
                age_q <= age_d;
                case (state_q)
                    ARB_IDLE: begin
                        if (!eu_lock) locked_q <= 1'b0;
                        if (grant) begin
                            state_q    <= ARB_ISSUE;
                            owner_q    <= w;
                            dp_req_q   <= 1'b1;
                            dp_addr_q  <= req_addr[w];
                            dp_dout_q  <= req_dout[w];
                            dp_write_q <= req_write[w];
                            dp_wide_q  <= req_wide[w];
                            dp_io_q    <= req_io[w];
                            if (winner == ARB_EU && eu_lock) locked_q <= 1'b1;
                        end
                    end
                    ARB_ISSUE: begin
                        dp_req_q <= 1'b0;
                        state_q  <= ARB_WAIT;
                    end
                    ARB_WAIT: begin
                        if (dp_ready) begin
                            if (!dp_write_q) rdata_q <= dp_din;
                            done_q  <= NREQ'(1) << owner_q;
                            owner_q <= ARB_NONE;
                            state_q <= ARB_IDLE;
                        end
                    end
                    default: state_q <= ARB_IDLE;
                endcase
            end
        end
    end

    assign done     = done_q;
    assign rdata    = rdata_q;
    assign owner    = owner_q;
    assign dp_addr  = dp_addr_q;
    assign dp_dout  = dp_dout_q;
    assign dp_write = dp_write_q;
    assign dp_wide  = dp_wide_q;
    assign dp_io    = dp_io_q;
    assign dp_req   = dp_req_q;

    a_owner_valid: assert property (@(posedge clk) disable iff (reset)
        (state_q != ARB_IDLE) |-> (owner_q != 2'(ARB_NONE)));
endmodule

// File: tb/tb_bus_arbiter_v35.sv
// tb_bus_arbiter_v35: directed and random checks of the arbiter against a transaction-level model
module tb_bus_arbiter_v35;
    logic            clk = 1'b0;
    logic            reset, ce_1, ce_2, eu_lock, dp_ready;
    logic [2:0]      req, req_write, req_wide, req_io, done;
    logic [2:0][19:0] req_addr;
    logic [2:0][15:0] req_dout;
    logic [15:0]     rdata, dp_dout, dp_din;
    logic [1:0]      owner;
    logic [19:0]     dp_addr;
    logic            dp_write, dp_wide, dp_io, dp_req;
    int              compared = 0;
    int              mismatched = 0;

    int              m_phase, m_owner;
    int              m_age[3];
    logic            m_locked, m_dpreq, m_write, m_wide, m_io;
    logic [2:0]      m_done;
    logic [15:0]     m_rdata, m_dout;
    logic [19:0]     m_addr;

    always #5 clk = ~clk;

    bus_arbiter_v35 dut (
        .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2),
        .req(req), .req_addr(req_addr), .req_dout(req_dout),
        .req_write(req_write), .req_wide(req_wide), .req_io(req_io),
        .eu_lock(eu_lock), .done(done), .rdata(rdata), .owner(owner),
        .dp_addr(dp_addr), .dp_dout(dp_dout), .dp_write(dp_write),
        .dp_wide(dp_wide), .dp_io(dp_io), .dp_req(dp_req),
        .dp_din(dp_din), .dp_ready(dp_ready)
    );

    function automatic int m_pick(input logic [2:0] r, input logic lk, input int a2);
        int ord[3] = '{1, 0, 2};
        if (lk) return r[0] ? 0 : 3;
        if (r[2] && a2 >= 8) return 2;
        for (int k = 0; k < 3; k++) if (r[ord[k]]) return ord[k];
        return 3;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_owner = 3; m_locked = 0; m_dpreq = 0; m_done = '0;
        m_rdata = '0; m_addr = '0; m_dout = '0; m_write = 0; m_wide = 0; m_io = 0;
        for (int i = 0; i < 3; i++) m_age[i] = 0;
    endtask

    task automatic m_edge(input logic c1);
        int w, a2;
        m_done = '0;
        if (c1) begin
            a2 = m_age[2];
            for (int i = 0; i < 3; i++)
                if (req[i] && m_owner != i && m_age[i] < 15) m_age[i]++;
            if (m_phase == 0) begin
                w = m_pick(req, m_locked && eu_lock, a2);
                if (!eu_lock) m_locked = 0;
                if (dp_ready && w != 3) begin
                    m_addr = req_addr[w]; m_dout = req_dout[w];
                    m_write = req_write[w]; m_wide = req_wide[w]; m_io = req_io[w];
                    m_owner = w; m_age[w] = 0; m_dpreq = 1; m_phase = 1;
                    if (w == 0 && eu_lock) m_locked = 1;
                end
            end else if (m_phase == 1) begin
                m_dpreq = 0; m_phase = 2;
            end else if (dp_ready) begin
                if (!m_write) m_rdata = dp_din;
                m_done = 3'b001 << m_owner;
                m_owner = 3; m_phase = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("owner", 32'(owner), m_owner);
        chk("done", 32'(done), 32'(m_done));
        chk("rdata", 32'(rdata), 32'(m_rdata));
        chk("dp_req", 32'(dp_req), 32'(m_dpreq));
        chk("dp_addr", 32'(dp_addr), 32'(m_addr));
        chk("dp_dout", 32'(dp_dout), 32'(m_dout));
        chk("dp_write", 32'(dp_write), 32'(m_write));
        chk("dp_wide", 32'(dp_wide), 32'(m_wide));
        chk("dp_io", 32'(dp_io), 32'(m_io));
    endtask

    task automatic step(input logic c1);
        ce_1 = c1; ce_2 = !c1;
        @(posedge clk);
        m_edge(c1);
        #1;
        chk_all();
    endtask

    initial begin
        int order[$];
        int ndma, got;
        reset = 1; ce_1 = 0; ce_2 = 0; eu_lock = 0; dp_ready = 0; dp_din = '0;
        req = '0; req_write = '0; req_wide = '0; req_io = '0; req_addr = '0; req_dout = '0;
        m_reset();
        @(posedge clk); #1;
        chk_all();
        chk("reset_owner", 32'(owner), 3);
        reset = 0;

        req_addr[0] = 20'h12345; req_wide = 3'b111; dp_ready = 1; dp_din = 16'hBEEF; req = 3'b001;
        step(1);
        chk("t1_owner", 32'(owner), 0);
        chk("t1_dp_req", 32'(dp_req), 1);
        chk("t1_addr", 32'(dp_addr), 32'h12345);
        step(0); step(1);
        chk("t1_dp_req_drop", 32'(dp_req), 0);
        step(0); step(1);
        chk("t1_done", 32'(done), 3'b001);
        chk("t1_rdata", 32'(rdata), 32'hBEEF);
        chk("t1_owner_free", 32'(owner), 3);
        req = 0;
        step(0);
        chk("t1_done_pulse", 32'(done), 0);

        req_addr[1] = 20'h22222; dp_din = 16'h1111; req = 3'b011;
        for (int k = 0; k < 40 && order.size() < 2; k++) begin
            step(k % 2 == 0);
            if (done != 0) begin
                order.push_back(done == 3'b010 ? 1 : done == 3'b001 ? 0 : 9);
                req = req & ~done;
            end
        end
        chk("t2_first", order.size() > 0 ? order[0] : 9, 1);
        chk("t2_second", order.size() > 1 ? order[1] : 9, 0);

        ndma = 0; got = 0; req = 3'b110;
        for (int k = 0; k < 120 && got == 0; k++) begin
            step(k % 2 == 0);
            if (done[1]) ndma++;
            if (done[2]) begin got = 1; req = 0; end
        end
        chk("t3_rfsh_done", got, 1);
        chk("t3_dma_before_rfsh", ndma, 3);

        eu_lock = 1; req_write = 3'b111; req_addr[0] = 20'h0A0A0; req = 3'b001; dp_ready = 1;
        step(1); chk("t4_grant_eu1", 32'(owner), 0); step(0);
        req = 3'b111; dp_ready = 0;
        repeat (4) begin step(1); step(0); end
        dp_ready = 1;
        step(1); chk("t4_done_eu1", 32'(done), 3'b001); step(0);
        req[0] = 0;
        repeat (2) begin step(1); chk("t4_idle_locked", 32'(owner), 3); step(0); end
        req[0] = 1; req_addr[0] = 20'h0B0B0;
        step(1); chk("t4_grant_eu2", 32'(owner), 0); step(0);
        step(1); step(0);
        step(1); chk("t4_done_eu2", 32'(done), 3'b001); step(0);
        req[0] = 0; eu_lock = 0;
        step(1); chk("t4_rfsh_after_unlock", 32'(owner), 2); step(0);
        step(1); step(0);
        step(1); chk("t4_done_rfsh", 32'(done), 3'b100); step(0);
        req[2] = 0;
        step(1); chk("t4_dma_grant", 32'(owner), 1); step(0);
        step(1); step(0);
        step(1); chk("t4_done_dma", 32'(done), 3'b010); step(0);
        req = 0;

        req_addr[1] = 20'hABCDE; req_dout[1] = 16'h5A5A; req = 3'b010;
        step(1); chk("t5_grant", 32'(owner), 1); step(0);
        dp_ready = 0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t5_no_done", 32'(done), 0);
            chk("t5_addr_stable", 32'(dp_addr), 32'hABCDE);
            chk("t5_dout_stable", 32'(dp_dout), 32'h5A5A);
            step(0);
        end
        dp_ready = 1;
        step(1); chk("t5_done", 32'(done), 3'b010); step(0);
        req = 0;

        req_write = 3'b000; req = 3'b001; dp_din = 16'h7777;
        step(1); step(0);
        dp_ready = 0;
        step(1); step(0);
        #2 reset = 1;
        #1;
        chk("t6_owner", 32'(owner), 3);
        chk("t6_dp_req", 32'(dp_req), 0);
        chk("t6_rdata", 32'(rdata), 0);
        chk("t6_addr", 32'(dp_addr), 0);
        m_reset();
        chk_all();
        req = 0; dp_ready = 1; reset = 0;
        for (int k = 0; k < 6; k++) begin
            step(k % 2 == 0);
            chk("t6_no_done", 32'(done), 0);
        end

        eu_lock = 0;
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 2) != 0);
            for (int i = 0; i < 3; i++) begin
                if (m_done[i]) req[i] = ($urandom_range(0, 3) == 0);
                else if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1;
                else if (req[i] && $urandom_range(0, 60) == 0) req[i] = 0;
                if ($urandom_range(0, 3) == 0) begin
                    req_addr[i] = 20'($urandom); req_dout[i] = 16'($urandom);
                    req_write[i] = 1'($urandom); req_wide[i] = 1'($urandom); req_io[i] = 1'($urandom);
                end
            end
            dp_ready = ($urandom_range(0, 3) != 0);
            dp_din = 16'($urandom);
            if ($urandom_range(0, 15) == 0) eu_lock = !eu_lock;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
